// File: rtl/rx_pkg.sv
// Shared types and constants for the receiver word packer.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    CLOSE = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_FRAME_WORDS  = 8;
  localparam int DEF_IDLE_TIMEOUT = 64;
  localparam int OVF_W            = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    logic [OVF_W-1:0] r;
    if (v == {OVF_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(OVF_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_frame_packer_if.sv
// Word input and AXI4-Stream output of the frame packer.
// "master" is the packer side (it sources the stream); "slave" is the
// surrounding environment that feeds words and sinks the stream.
interface rx_frame_packer_if
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  modport master (
    input  s_data, s_valid, flush, m_axis_tready,
    output s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    output s_data, s_valid, flush, m_axis_tready,
    input  s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

endinterface

// File: rtl/rx_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a look-ahead head read.
module rx_sync_fifo
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic                  wr_ok_s;
  logic                  rd_ok_s;

  // Same index with differing wrap bits means every slot is occupied.
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign count   = wr_ptr_r - rd_ptr_r;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && !empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Advance read and write pointers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/rx_frame_packer.sv
// Buffers receiver words and emits them as AXI4-Stream frames of FRAME_WORDS
// beats. The last buffered word is held back so tlast can still be placed on
// it; an idle timeout or a flush closes a partial frame with tuser set.
module rx_frame_packer
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int FRAME_WORDS  = DEF_FRAME_WORDS,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  rx_frame_packer_if.master           bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [OVF_W-1:0]            overflow_count
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = $clog2(FRAME_WORDS);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_TWO   = CNT_W'(2);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);

  logic [CNT_W-1:0]      cnt_s;
  logic                  full_s;
  logic                  empty_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  wr_en_s;
  logic                  out_free_s;
  logic                  close_req_s;
  logic                  can_pop_s;
  logic                  pop_s;
  logic                  pop_last_s;
  logic                  pop_user_s;
  state_e                state_s;

  state_e                state_r;
  logic [BEAT_W-1:0]     beat_cnt_r;
  logic [IDLE_W-1:0]     idle_cnt_r;
  logic                  flush_pend_r;
  logic [DATA_WIDTH-1:0] tdata_r;
  logic                  tvalid_r;
  logic                  tlast_r;
  logic                  tuser_r;
  logic [OVF_W-1:0]      ovf_r;

  rx_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (wr_en_s),
    .wr_data (bus.s_data),
    .rd_en   (pop_s),
    .rd_data (rd_data_s),
    .count   (cnt_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign bus.s_ready        = !full_s;
  assign wr_en_s            = bus.s_valid && !full_s;
  assign out_free_s         = !tvalid_r || bus.m_axis_tready;
  assign close_req_s        = (idle_cnt_r == IDLE_MAX) || flush_pend_r;
  assign pop_s              = can_pop_s && out_free_s;

  assign bus.m_axis_tdata   = tdata_r;
  assign bus.m_axis_tvalid  = tvalid_r;
  assign bus.m_axis_tlast   = tlast_r;
  assign bus.m_axis_tuser   = tuser_r;
  assign fifo_level         = cnt_s;
  assign overflow_count     = ovf_r;

  // Decide whether the head word may leave and how it is marked.
  always_comb begin
    can_pop_s  = 1'b0;
    pop_last_s = 1'b0;
    pop_user_s = 1'b0;
    if (cnt_s >= CNT_TWO) begin
      can_pop_s  = 1'b1;
      pop_last_s = (beat_cnt_r == BEAT_LAST);
    end else if (cnt_s == CNT_ONE) begin
      if (beat_cnt_r == BEAT_LAST) begin
        can_pop_s  = 1'b1;
        pop_last_s = 1'b1;
      end else if (close_req_s) begin
        can_pop_s  = 1'b1;
        pop_last_s = 1'b1;
        pop_user_s = 1'b1;
      end else begin
        can_pop_s  = 1'b0;
      end
    end else begin
      can_pop_s = 1'b0;
    end
  end

  // Frame state next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s && !pop_last_s) begin
          state_s = FRAME;
        end else begin
          state_s = IDLE;
        end
      end
      FRAME: begin
        if (pop_s && pop_last_s) begin
          state_s = IDLE;
        end else if (close_req_s && !out_free_s) begin
          state_s = CLOSE;
        end else begin
          state_s = FRAME;
        end
      end
      CLOSE: begin
        if (pop_s && pop_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = CLOSE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Frame state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Beat position within the current frame.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_r <= BEAT_ZERO;
    end else if (pop_s) begin
      beat_cnt_r <= pop_last_s ? BEAT_ZERO : beat_cnt_r + BEAT_ONE;
    end
  end

  // Idle time of a lone held word, saturating at the timeout.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idle_cnt_r <= IDLE_ZERO;
    end else if (wr_en_s || pop_s) begin
      idle_cnt_r <= IDLE_ZERO;
    end else if (cnt_s == CNT_ONE) begin
      if (idle_cnt_r != IDLE_MAX) begin
        idle_cnt_r <= idle_cnt_r + IDLE_ONE;
      end
    end else begin
      idle_cnt_r <= IDLE_ZERO;
    end
  end

  // Pending flush; a flush with nothing buffered and no open frame is dropped,
  // and the closing pop retires it (winning over a coincident new flush).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      flush_pend_r <= 1'b0;
    end else if (pop_s && pop_last_s) begin
      flush_pend_r <= 1'b0;
    end else if (bus.flush && !(empty_s && (beat_cnt_r == BEAT_ZERO))) begin
      flush_pend_r <= 1'b1;
    end
  end

  // Stream output register: load on pop, go invalid when free and idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_r  <= {DATA_WIDTH{1'b0}};
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tuser_r  <= 1'b0;
    end else if (pop_s) begin
      tdata_r  <= rd_data_s;
      tvalid_r <= 1'b1;
      tlast_r  <= pop_last_s;
      tuser_r  <= pop_user_s;
    end else if (out_free_s) begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tuser_r  <= 1'b0;
    end
  end

  // Count cycles in which an offered word was refused.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_r <= {OVF_W{1'b0}};
    end else if (bus.s_valid && full_s) begin
      ovf_r <= sat_inc(ovf_r);
    end
  end

endmodule

// File: tb/tb_rx_frame_packer.sv
// Self-checking bench for rx_frame_packer: scenario tasks compare the
// collected stream against frames computed from the framing rules.
module tb_rx_frame_packer;
  import rx_pkg::*;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int FW = 8;
  localparam int TO = 64;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    int            cyc;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_count;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  beat_t       got_q[$];
  beat_t       exp_q[$];

  rx_frame_packer_if #(.DATA_WIDTH(DW)) bus ();

  rx_frame_packer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW), .IDLE_TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus),
    .fifo_level(fifo_level), .overflow_count(overflow_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Record every accepted beat, sampled mid-cycle.
  always @(negedge aclk) begin
    if (aresetn && bus.m_axis_tvalid && bus.m_axis_tready)
      got_q.push_back('{bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser, cyc});
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.flush = 1'b0;
    bus.m_axis_tready = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
  endtask

  // Back-to-back words base, base+1, ... (caller guarantees room).
  task automatic write_burst(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = base + DW'(i);
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    ok = (got_q.size() >= n);
  endtask

  // Reference framing: consecutive words, tlast on every FW-th, never tuser.
  function automatic void add_frames(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{base + DW'(i), ((i % FW) == FW - 1), 1'b0, 0});
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got %b want 0", bus.m_axis_tvalid); end
    checks++; if ({bus.m_axis_tlast, bus.m_axis_tuser} !== 2'b00) begin failures++; $display("FAIL reset_tlast_tuser got %b want 00", {bus.m_axis_tlast, bus.m_axis_tuser}); end
    checks++; if (bus.m_axis_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got %h want 0", bus.m_axis_tdata); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (overflow_count !== 16'd0) begin failures++; $display("FAIL reset_ovf got %0d want 0", overflow_count); end
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
  endtask

  task automatic test_full_frames();
    bit ok;
    do_reset();
    bus.m_axis_tready = 1'b1;
    write_burst(16, 32'h1);
    wait_beats(16, 100, ok);
    repeat (5) tick();
    add_frames(32'h1, 16);
    checks++; if (got_q.size() !== 16) begin failures++; $display("FAIL full_count got %0d want 16", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin failures++; $display("FAIL full_beat%0d got none want %h", i, exp_q[i].data); end
      else if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].user !== exp_q[i].user) begin
        failures++; $display("FAIL full_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
    if (got_q.size() == 16) begin
      checks++; if (got_q[15].cyc - got_q[0].cyc !== 15) begin failures++; $display("FAIL full_throughput got %0d want 15", got_q[15].cyc - got_q[0].cyc); end
    end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL full_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    bus.m_axis_tready = 1'b1;
    write_burst(3, 32'h1);
    wait_beats(3, TO + 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_count got %0d want 3", got_q.size()); end
    else begin
      exp_q.push_back('{32'h1, 1'b0, 1'b0, 0});
      exp_q.push_back('{32'h2, 1'b0, 1'b0, 0});
      exp_q.push_back('{32'h3, 1'b1, 1'b1, 0});
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].user !== exp_q[i].user) begin
          failures++; $display("FAIL timeout_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
        end
      end
      checks++; if (got_q[1].cyc - got_q[0].cyc !== 1) begin failures++; $display("FAIL timeout_stream got %0d want 1", got_q[1].cyc - got_q[0].cyc); end
      // Held word leaves TO+1 edges after the previous pop.
      checks++; if (got_q[2].cyc - got_q[1].cyc !== TO + 1) begin failures++; $display("FAIL timeout_delay got %0d want %0d", got_q[2].cyc - got_q[1].cyc, TO + 1); end
    end
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    bus.m_axis_tready = 1'b1;
    write_burst(5, 32'h1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_beats(5, 20, ok);
    repeat (5) tick();
    // Empty and between frames: this flush must have no effect.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (3) tick();
    write_burst(8, 32'h6);
    wait_beats(13, 60, ok);
    repeat (3) tick();
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{DW'(i + 1), (i == 4), (i == 4), 0});
    add_frames(32'h6, 8);
    checks++; if (got_q.size() !== 13) begin failures++; $display("FAIL flush_count got %0d want 13", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin failures++; $display("FAIL flush_beat%0d got none want %h", i, exp_q[i].data); end
      else if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].user !== exp_q[i].user) begin
        failures++; $display("FAIL flush_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    bus.m_axis_tready = 1'b0;
    // 20 cycles of s_valid: one word sits in the output register, 16 fill
    // the FIFO, the last 3 cycles are refused.
    for (int i = 0; i < 20; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = DW'(i + 1);
      tick();
    end
    bus.s_valid = 1'b0;
    checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL bp_level got %0d want 16", fifo_level); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready got %b want 0", bus.s_ready); end
    checks++; if (overflow_count !== 16'd3) begin failures++; $display("FAIL bp_ovf got %0d want 3", overflow_count); end
    checks++; if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast} !== {1'b1, 32'h1, 1'b0}) begin
      failures++; $display("FAIL bp_stall0 got %b/%h/%b want 1/00000001/0", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast); end
    repeat (6) tick();
    checks++; if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast} !== {1'b1, 32'h1, 1'b0}) begin
      failures++; $display("FAIL bp_stall1 got %b/%h/%b want 1/00000001/0", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast); end
    bus.m_axis_tready = 1'b1;
    wait_beats(17, TO + 60, ok);
    add_frames(32'h1, 16);
    exp_q.push_back('{32'h11, 1'b1, 1'b1, 0});
    checks++; if (!ok) begin failures++; $display("FAIL bp_count got %0d want 17", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin failures++; $display("FAIL bp_beat%0d got none want %h", i, exp_q[i].data); end
      else if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].user !== exp_q[i].user) begin
        failures++; $display("FAIL bp_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
  endtask

  task automatic test_random_ready();
    localparam int N = 48;
    logic [DW-1:0] base;
    do_reset();
    base = $urandom();
    fork
      begin
        int  i = 0;
        bit  acc;
        while (i < N) begin
          bus.s_valid = ($urandom_range(0, 3) != 0);
          bus.s_data = base + DW'(i);
          @(negedge aclk);
          acc = bus.s_valid && bus.s_ready;
          tick();
          if (acc) i++;
        end
        bus.s_valid = 1'b0;
      end
      begin
        int t = 0;
        while (got_q.size() < N && t < 3000) begin
          bus.m_axis_tready = ($urandom_range(0, 1) == 1);
          tick();
          t++;
        end
        bus.m_axis_tready = 1'b1;
      end
    join
    repeat (4) tick();
    add_frames(base, N);
    checks++; if (got_q.size() !== N) begin failures++; $display("FAIL rand_count got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin failures++; $display("FAIL rand_beat%0d got none want %h", i, exp_q[i].data); end
      else if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].user !== exp_q[i].user) begin
        failures++; $display("FAIL rand_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    bus.m_axis_tready = 1'b1;
    write_burst(6, 32'h50);
    wait_beats(4, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_pre_count got %0d want 4", got_q.size()); end
    aresetn = 1'b0;
    #1;
    checks++; if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata} !== {3'b000, 32'h0}) begin
      failures++; $display("FAIL rst_outputs got %b%b%b/%h want 000/00000000", bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata); end
    checks++; if ({fifo_level, bus.s_ready} !== {5'd0, 1'b1}) begin
      failures++; $display("FAIL rst_level_ready got %0d/%b want 0/1", fifo_level, bus.s_ready); end
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    got_q.delete();
    write_burst(8, 32'h100);
    wait_beats(8, 40, ok);
    repeat (TO + 10) tick();
    add_frames(32'h100, 8);
    checks++; if (got_q.size() !== 8) begin failures++; $display("FAIL rst_post_count got %0d want 8", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin failures++; $display("FAIL rst_beat%0d got none want %h", i, exp_q[i].data); end
      else if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].user !== exp_q[i].user) begin
        failures++; $display("FAIL rst_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.flush = 1'b0;
    bus.m_axis_tready = 1'b0;
    test_reset();
    test_full_frames();
    test_timeout();
    test_flush();
    test_backpressure();
    test_random_ready();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
